sfx_scheduler: RTL and testbench

//  Arbitrates the right-channel tone divider between background music and five sound-effect requesters.

---
 rtl/sfx_scheduler_pkg.sv | 30 +++
 rtl/sfx_scheduler_if.sv | 17 +
 rtl/sfx_scheduler_rom.sv | 26 ++
 rtl/sfx_scheduler.sv | 113 +++++++++++
 tb/tb_sfx_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sfx_scheduler_pkg.sv
// Shared types and constants for the sound-effect scheduler: state encoding,
// note divider values, requester count and the "no effect" id.
package sfx_scheduler_pkg;

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int NUM_REQ = 5;
  localparam int NOTES   = 4;

  localparam logic [2:0]  ID_NONE  = 3'd7;

  localparam logic [26:0] DIV_DO   = 27'd191571;
  localparam logic [26:0] DIV_RE   = 27'd170648;
  localparam logic [26:0] DIV_MI   = 27'd151515;
  localparam logic [26:0] DIV_FA   = 27'd143266;
  localparam logic [26:0] DIV_SO   = 27'd127551;
  localparam logic [26:0] DIV_LA   = 27'd113636;
  localparam logic [26:0] DIV_SI   = 27'd101214;
  localparam logic [26:0] REST     = 27'd0;
  localparam logic [26:0] REST_DIV = 27'd1;

  // Lowest set index wins; ID_NONE when nothing is set.
  function automatic logic [2:0] first_set(input logic [NUM_REQ-1:0] v);
    first_set = ID_NONE;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) first_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/sfx_scheduler_if.sv
// Request/divider bundle between game logic, the scheduler and the buzzer.
interface sfx_scheduler_if;
  import sfx_scheduler_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [26:0]        bgm_div;
  logic               mute;
  logic [26:0]        div_out;
  logic               busy;
  logic [2:0]         active_id;
  logic               done;

  modport master (output req, bgm_div, mute,
                  input  div_out, busy, active_id, done);
  modport slave  (input  req, bgm_div, mute,
                  output div_out, busy, active_id, done);
endinterface

// File: rtl/sfx_scheduler_rom.sv
// Fixed 4-note effect table; REST entries come out as 0 and are mapped later.
module sfx_scheduler_rom
  import sfx_scheduler_pkg::*;
(
  input  logic [2:0]  id_i,
  input  logic [1:0]  idx_i,
  output logic [26:0] div_o
);

  // Packed so that seq[0] is the first note of the effect.
  logic [3:0][26:0] seq;

  always_comb begin
    seq = {REST, REST, REST, REST};
    case (id_i)
      3'd0:    seq = {DIV_DO, DIV_RE, DIV_MI, DIV_SO};
      3'd1:    seq = {DIV_LA, DIV_SO, DIV_MI, DIV_DO};
      3'd2:    seq = {DIV_MI, REST,   DIV_MI, DIV_MI};
      3'd3:    seq = {DIV_SO, DIV_LA, DIV_SO, DIV_LA};
      3'd4:    seq = {REST,   DIV_RE, REST,   DIV_RE};
      default: seq = {REST, REST, REST, REST};
    endcase
    div_o = seq[idx_i];
  end

endmodule

// File: rtl/sfx_scheduler.sv
// Right-channel divider arbiter: background music vs. five prioritised,
// queued, preempting 4-note sound effects.
//
//   state | meaning
//   IDLE  | no effect; div_out follows bgm_div
//   PLAY  | effect sel_q playing note idx_q, tick_q cycles into the note
module sfx_scheduler
  import sfx_scheduler_pkg::*;
#(
  parameter int NOTE_TICKS = 10_000_000
) (
  input logic            clk,
  input logic            rst_n,
  sfx_scheduler_if.slave bus
);

  localparam int            TW        = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] req_q, pend_q, pend_d;
  logic [NUM_REQ-1:0] new_w, cand, gmask;
  logic [2:0]         sel_q, sel_d, winner;
  logic [1:0]         idx_q, idx_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [26:0]        rom_div;
  logic               grant, last_note;

  assign new_w     = bus.req & ~req_q;
  assign cand      = pend_q | new_w;
  assign winner    = first_set(cand);
  assign last_note = (state_q == PLAY) && (tick_q == TICK_LAST) && (idx_q == 2'(NOTES - 1));

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand != '0) grant = 1'b1;
      end
      PLAY: begin
        if (last_note) begin
          if (cand != '0) begin
            grant = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            tick_d  = '0;
          end
        end else if ((cand != '0) && (winner < sel_q)) begin
          grant = 1'b1;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          idx_d  = idx_q + 2'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = PLAY;
      sel_d   = winner;
      idx_d   = '0;
      tick_d  = '0;
    end
  end

  // A fresh edge on a bit that was already queued survives its own grant.
  assign gmask  = grant ? (NUM_REQ'(1) << winner) : '0;
  assign pend_d = (cand & ~gmask) | (pend_q & new_w & gmask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      sel_q   <= ID_NONE;
      idx_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= bus.req;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
    end
  end

  sfx_scheduler_rom u_rom (
    .id_i  (sel_q),
    .idx_i (idx_q),
    .div_o (rom_div)
  );

  always_comb begin
    bus.div_out = bus.bgm_div;
    if (bus.mute) begin
      bus.div_out = REST_DIV;
    end else if (state_q == PLAY) begin
      bus.div_out = (rom_div == REST) ? REST_DIV : rom_div;
    end
  end

  assign bus.busy      = (state_q == PLAY);
  assign bus.active_id = (state_q == PLAY) ? sel_q : ID_NONE;
  assign bus.done      = last_note;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Self-checking bench for sfx_scheduler with NOTE_TICKS=4: directed scenarios
// plus randomized requests against an elapsed-time reference model.
module tb_sfx_scheduler;

  localparam int NT  = 4;
  localparam int LEN = 4 * NT;
  localparam int BGM = 191571;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sfx_scheduler_if bus ();

  sfx_scheduler #(.NOTE_TICKS(NT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  int tbl [5][4] = '{
    '{127551, 151515, 170648, 191571},
    '{191571, 151515, 127551, 113636},
    '{151515, 151515, 0,      151515},
    '{113636, 127551, 113636, 127551},
    '{170648, 0,      170648, 0}
  };

  wire [31:0] obs = {bus.div_out, bus.busy, bus.active_id, bus.done};

  function automatic logic [31:0] pk(int div, bit busy, int id, bit done);
    return {27'(div), busy, 3'(id), done};
  endfunction

  function automatic int note(int id, int c);
    int d = tbl[id][c / NT];
    return (d == 0) ? 1 : d;
  endfunction

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0; bus.req = '0; bus.bgm_div = 27'(BGM); bus.mute = 1'b0;
    repeat (2) @(negedge clk);
    exp = pk(BGM, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_hold got %h want %h", obs, exp); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_release got %h want %h", obs, exp); end
  endtask

  task automatic test_single();
    logic [31:0] exp;
    bus.req = 5'b10000; @(negedge clk); bus.req = '0;
    for (int c = 0; c < LEN; c++) begin
      exp = pk(note(4, c), 1, 4, c == LEN - 1);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL single c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    exp = pk(BGM, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL single_idle got %h want %h", obs, exp); end
  endtask

  task automatic test_preempt();
    logic [31:0] exp;
    bus.req = 5'b10000; @(negedge clk); bus.req = '0;
    for (int c = 0; c < NT + 2; c++) begin
      exp = pk(note(4, c), 1, 4, 0);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL preempt_e4 c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    bus.req = 5'b00001; @(negedge clk); bus.req = '0;
    for (int c = 0; c < LEN; c++) begin
      exp = pk(note(0, c), 1, 0, c == LEN - 1);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL preempt_e0 c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      exp = pk(BGM, 0, 7, 0);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL preempt_no_resume c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    bus.req = 5'b01010; @(negedge clk); bus.req = '0;
    for (int c = 0; c < 2 * LEN; c++) begin
      if (c < LEN) exp = pk(note(1, c), 1, 1, c == LEN - 1);
      else         exp = pk(note(3, c - LEN), 1, 3, c == 2 * LEN - 1);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL b2b c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    exp = pk(BGM, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL b2b_idle got %h want %h", obs, exp); end
  endtask

  task automatic test_reset_held();
    logic [31:0] exp;
    rst_n = 1'b0; bus.req = 5'b00100;
    repeat (2) @(negedge clk);
    exp = pk(BGM, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL held_in_reset got %h want %h", obs, exp); end
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < LEN + 6; c++) begin
      if (c < LEN) exp = pk(note(2, c), 1, 2, c == LEN - 1);
      else         exp = pk(BGM, 0, 7, 0);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL held_once c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  task automatic test_mute_reset();
    logic [31:0] exp;
    bus.mute = 1'b1;
    bus.req = 5'b00001; @(negedge clk); bus.req = '0;
    for (int c = 0; c < LEN + 2; c++) begin
      if (c < LEN) exp = pk(1, 1, 0, c == LEN - 1);
      else         exp = pk(1, 0, 7, 0);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL mute c=%0d got %h want %h", c, obs, exp); end
      @(negedge clk);
    end
    bus.req = 5'b00001; @(negedge clk); bus.req = '0;
    repeat (5) @(negedge clk);
    exp = pk(1, 1, 0, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL mute_mid got %h want %h", obs, exp); end
    #2 rst_n = 1'b0;
    #1;
    exp = pk(1, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL async_reset_muted got %h want %h", obs, exp); end
    bus.mute = 1'b0;
    #1;
    exp = pk(BGM, 0, 7, 0);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL async_reset got %h want %h", obs, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_pending_lost got %h want %h", obs, exp); end
  endtask

  // Model tracks the playing effect and cycles elapsed since it started.
  task automatic test_random();
    logic [31:0] exp;
    logic [4:0]  m_prev, m_pend, old_pend, nw, cand, r;
    int          m_play, m_el, m_bgm, w;
    bit          m_mute, grant;
    rst_n = 1'b0; bus.req = '0; bus.mute = 1'b0; bus.bgm_div = 27'(BGM);
    @(negedge clk);
    rst_n = 1'b1;
    m_prev = '0; m_pend = '0; m_play = -1; m_el = 0; m_bgm = BGM; m_mute = 1'b0; r = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_play < 0) exp = pk(m_mute ? 1 : m_bgm, 0, 7, 0);
      else            exp = pk(m_mute ? 1 : note(m_play, m_el), 1, m_play, m_el == LEN - 1);
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL random cyc=%0d got %h want %h", cyc, obs, exp); end

      for (int i = 0; i < 5; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
      if ($urandom_range(0, 15) == 0) m_mute = ~m_mute;
      if ($urandom_range(0, 31) == 0) m_bgm = int'($urandom_range(2, 134217727));
      bus.req = r; bus.mute = m_mute; bus.bgm_div = 27'(m_bgm);

      nw = r & ~m_prev;
      cand = m_pend | nw;
      w = -1;
      for (int i = 4; i >= 0; i--) if (cand[i]) w = i;
      grant = 1'b0;
      if (m_play < 0) begin
        if (w >= 0) grant = 1'b1;
      end else if (m_el == LEN - 1) begin
        if (w >= 0) grant = 1'b1;
        else m_play = -1;
      end else if (w >= 0 && w < m_play) begin
        grant = 1'b1;
      end else begin
        m_el++;
      end
      old_pend = m_pend;
      m_pend = cand;
      if (grant) begin
        m_pend[w] = old_pend[w] & nw[w];
        m_play = w;
        m_el = 0;
      end
      m_prev = r;
      @(negedge clk);
    end
    bus.req = '0; bus.mute = 1'b0; bus.bgm_div = 27'(BGM);
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_back_to_back();
    test_reset_held();
    test_mute_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
